alu_exec_unit: RTL

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_exec_unit_if.sv | 29 ++
 rtl/alu_exec_unit.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit_if.sv
// Request/result handshake bundle for alu_exec_unit.
// The master side issues operations and consumes results; the slave side is the execution unit.
interface alu_exec_unit_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned OPW   = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       alu_op;
  logic [OPW-1:0]   opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             ovf;
  logic             illegal;

  modport master (
    output in_valid, alu_op, opcode, a, b, out_ready,
    input  in_ready, out_valid, result, zero, ovf, illegal
  );

  modport slave (
    input  in_valid, alu_op, opcode, a, b, out_ready,
    output in_ready, out_valid, result, zero, ovf, illegal
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Handshaked ALU: single-cycle add/sub/logic/shift/compare ops and an iterative shift-add multiply.
// The result is held in a register until the consumer takes it.
module alu_exec_unit #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned OPW   = 4
) (
  input logic             clk,
  input logic             rst,
  alu_exec_unit_if.slave  bus
);

  localparam int unsigned ShW  = $clog2(WIDTH);
  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StBusy, StHold} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] res_q;
  logic             ovf_q, illegal_q;
  logic [WIDTH-1:0] acc_q, mul_a_q, mul_b_q;
  logic [CntW-1:0]  cnt_q;

  logic             in_ready, accept, is_mul, mul_done;
  logic [WIDTH-1:0] sum, diff, op_res, acc_d;
  logic             add_ovf, sub_ovf, op_ovf, op_ill, shift_big;

  // Single-cycle datapath
  always_comb begin
    sum       = bus.a + bus.b;
    diff      = bus.a - bus.b;
    add_ovf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
    sub_ovf   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
    shift_big = bus.b >= WIDTH'(WIDTH);
    op_res    = sum;
    op_ovf    = add_ovf;
    op_ill    = 1'b0;
    unique case (bus.alu_op)
      2'b10: begin
        op_res = sum;
        op_ovf = add_ovf;
      end
      2'b01: begin
        op_res = diff;
        op_ovf = sub_ovf;
      end
      2'b00: begin
        op_ovf = 1'b0;
        case (bus.opcode)
          OPW'(2): begin
            op_res = sum;
            op_ovf = add_ovf;
          end
          OPW'(3): begin
            op_res = diff;
            op_ovf = sub_ovf;
          end
          OPW'(4): op_res = ~bus.a;
          OPW'(5): op_res = shift_big ? '0 : bus.a << bus.b[ShW-1:0];
          OPW'(6): op_res = shift_big ? '0 : bus.a >> bus.b[ShW-1:0];
          OPW'(7): op_res = bus.a & bus.b;
          OPW'(8): op_res = bus.a | bus.b;
          OPW'(9): op_res = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
          default: begin
            // Unknown opcodes still execute as add, flagged illegal.
            op_res = sum;
            op_ovf = add_ovf;
            op_ill = 1'b1;
          end
        endcase
      end
      default: begin
        op_res = '0;
        op_ovf = 1'b0;
      end
    endcase
  end

  assign in_ready = (state_q == StIdle) || ((state_q == StHold) && bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign is_mul   = bus.alu_op == 2'b11;
  assign mul_done = (state_q == StBusy) && (cnt_q == CntW'(WIDTH - 1));
  assign acc_d    = acc_q + (mul_b_q[0] ? mul_a_q : '0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = is_mul ? StBusy : StHold;
      StBusy: if (mul_done) state_d = StHold;
      StHold: begin
        if (accept)             state_d = is_mul ? StBusy : StHold;
        else if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q     <= '0;
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
      acc_q     <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      cnt_q     <= '0;
    end else if (accept) begin
      if (is_mul) begin
        acc_q   <= '0;
        mul_a_q <= bus.a;
        mul_b_q <= bus.b;
        cnt_q   <= '0;
      end else begin
        res_q     <= op_res;
        ovf_q     <= op_ovf;
        illegal_q <= op_ill;
      end
    end else if (state_q == StBusy) begin
      // One multiplier bit per cycle: add shifted multiplicand, then advance.
      acc_q   <= acc_d;
      mul_a_q <= {mul_a_q[WIDTH-2:0], 1'b0};
      mul_b_q <= {1'b0, mul_b_q[WIDTH-1:1]};
      cnt_q   <= cnt_q + CntW'(1);
      if (mul_done) begin
        res_q     <= acc_d;
        ovf_q     <= 1'b0;
        illegal_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = state_q == StHold;
  assign bus.result    = res_q;
  assign bus.zero      = res_q == '0;
  assign bus.ovf       = ovf_q;
  assign bus.illegal   = illegal_q;

endmodule
